// File: rtl/serial_mmio_pkg.sv
// Shared constants, FSM state types and the STATUS register layout for serial_mmio.
package serial_mmio_pkg;

   localparam logic RST_ENABLE = 1'b1;

   localparam int unsigned DATA_W = 8;

   localparam logic [1:0] SER_DATA_ADDR = 2'd0;
   localparam logic [1:0] SER_STAT_ADDR = 2'd1;
   localparam logic [1:0] SER_CTRL_ADDR = 2'd2;

   // Bit positions that STATUS and CTRL writes act on
   localparam int unsigned STAT_RX_OVR    = 3;
   localparam int unsigned STAT_TX_OVF    = 4;
   localparam int unsigned CTRL_RX_IRQ_EN = 0;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ACK  = 2'd1,
      R_WAIT = 2'd2
   } rx_state_e;

   typedef enum logic [1:0] {
      T_IDLE  = 2'd0,
      T_START = 2'd1,
      T_HOLD  = 2'd2
   } tx_state_e;

   typedef struct packed {
      logic [1:0] rsvd;
      logic       tx_idle;
      logic       tx_ovf;
      logic       rx_ovr;
      logic       tx_empty;
      logic       tx_full;
      logic       rx_avail;
   } status_t;

endpackage

// File: rtl/serial_mmio_if.sv
// CPU-side register bus of serial_mmio: one-cycle request, registered ack/rdata.
interface serial_mmio_if;
   logic       ce;
   logic       we;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       ack;

   modport master (output ce, we, addr, wdata, input rdata, ack);
   modport slave  (input ce, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/serial_mmio_fifo.sv
// Byte FIFO with simultaneous push/pop; a pop in the same cycle frees a slot for a push into a full FIFO.
module serial_mmio_fifo
   import serial_mmio_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned PTR_W  = 4,
   parameter int unsigned WIDTH  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_c_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic             full_q;
   logic             empty_q;
   logic             push_ok;
   logic             pop_ok;

   assign pop_ok  = pop_i & ~empty_q;
   assign push_ok = push_i & (~full_q | pop_ok);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   // Flags are registered from the next count so they never lag the pointers
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == FULL_CNT);
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_c_o = mem_q[rd_ptr_q];
   assign full_o   = full_q;
   assign empty_o  = empty_q;
   assign count_o  = count_q;

endmodule

// File: rtl/serial_mmio.sv
// Memory-mapped front end for serial_port: RX/TX byte FIFOs, register decode,
// the int_req/int_ack and write_enable/write_not_busy handshakes, and a level CPU interrupt.
module serial_mmio
   import serial_mmio_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PTR_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   serial_mmio_if.slave      bus,
   output logic              cpu_irq_o,
   input  logic              sp_int_req_i,
   input  logic [DATA_W-1:0] sp_rx_data_i,
   output logic              sp_int_ack_o,
   output logic [DATA_W-1:0] sp_tx_data_o,
   output logic              sp_write_enable_o,
   input  logic              sp_write_not_busy_i
);

   rx_state_e         rx_state_q;
   tx_state_e         tx_state_q;
   logic              sp_int_ack_q;
   logic              sp_write_enable_q;
   logic [DATA_W-1:0] sp_tx_data_q;
   logic              ack_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              rx_irq_en_q;
   logic              rx_ovr_q;
   logic              tx_ovf_q;
   logic              cpu_irq_q;

   logic              rx_full, rx_empty, tx_full, tx_empty;
   logic [PTR_W:0]    rx_count, tx_count;
   logic [DATA_W-1:0] rx_head, tx_head;
   logic              rd_access, wr_access;
   logic              rx_push, rx_pop, tx_push, tx_pop;
   logic              rx_ovr_set, tx_ovf_set, rx_ovr_clr, tx_ovf_clr;
   logic              ctrl_wr;
   status_t           status;

   assign rd_access = bus.ce & ~bus.we;
   assign wr_access = bus.ce &  bus.we;
   assign ctrl_wr   = wr_access & (bus.addr == SER_CTRL_ADDR);

   assign rx_push = (rx_state_q == R_IDLE) & sp_int_req_i;
   assign rx_pop  = rd_access & (bus.addr == SER_DATA_ADDR);
   assign tx_push = wr_access & (bus.addr == SER_DATA_ADDR);
   assign tx_pop  = (tx_state_q == T_IDLE) & ~tx_empty & sp_write_not_busy_i;

   // A full FIFO implies non-empty, so a concurrent pop always succeeds and saves the push
   assign rx_ovr_set = rx_push & rx_full & ~rx_pop;
   assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
   assign rx_ovr_clr = wr_access & (bus.addr == SER_STAT_ADDR) & bus.wdata[STAT_RX_OVR];
   assign tx_ovf_clr = wr_access & (bus.addr == SER_STAT_ADDR) & bus.wdata[STAT_TX_OVF];

   serial_mmio_fifo #(
      .DEPTH (FIFO_DEPTH),
      .PTR_W (PTR_W),
      .WIDTH (DATA_W)
   ) u_rx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (rx_push),
      .wdata_i  (sp_rx_data_i),
      .pop_i    (rx_pop),
      .head_c_o (rx_head),
      .full_o   (rx_full),
      .empty_o  (rx_empty),
      .count_o  (rx_count)
   );

   serial_mmio_fifo #(
      .DEPTH (FIFO_DEPTH),
      .PTR_W (PTR_W),
      .WIDTH (DATA_W)
   ) u_tx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (tx_push),
      .wdata_i  (bus.wdata),
      .pop_i    (tx_pop),
      .head_c_o (tx_head),
      .full_o   (tx_full),
      .empty_o  (tx_empty),
      .count_o  (tx_count)
   );

   always_comb begin
      status          = '0;
      status.rx_avail = (rx_count != '0);
      status.tx_full  = tx_full;
      status.tx_empty = (tx_count == '0);
      status.rx_ovr   = rx_ovr_q;
      status.tx_ovf   = tx_ovf_q;
      status.tx_idle  = (tx_state_q == T_IDLE);
   end

   // Read mux; non-read cycles return zero
   always_comb begin
      rdata_d = '0;
      if (rd_access) begin
         case (bus.addr)
            SER_DATA_ADDR: rdata_d = rx_empty ? '0 : rx_head;
            SER_STAT_ADDR: rdata_d = status;
            SER_CTRL_ADDR: rdata_d = {7'b0, rx_irq_en_q};
            default:       rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         rx_irq_en_q <= 1'b0;
         rx_ovr_q    <= 1'b0;
         tx_ovf_q    <= 1'b0;
         cpu_irq_q   <= 1'b0;
      end else begin
         ack_q    <= bus.ce;
         rdata_q  <= rdata_d;
         if (ctrl_wr) rx_irq_en_q <= bus.wdata[CTRL_RX_IRQ_EN];
         rx_ovr_q  <= rx_ovr_set | (rx_ovr_q & ~rx_ovr_clr);
         tx_ovf_q  <= tx_ovf_set | (tx_ovf_q & ~tx_ovf_clr);
         cpu_irq_q <= rx_irq_en_q & status.rx_avail;
      end
   end

   // RX handshake: capture on int_req, one-cycle int_ack, then wait for int_req to drop
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         rx_state_q   <= R_IDLE;
         sp_int_ack_q <= 1'b0;
      end else begin
         case (rx_state_q)
            R_IDLE: begin
               if (sp_int_req_i) begin
                  rx_state_q   <= R_ACK;
                  sp_int_ack_q <= 1'b1;
               end
            end
            R_ACK: begin
               rx_state_q   <= R_WAIT;
               sp_int_ack_q <= 1'b0;
            end
            R_WAIT: begin
               if (!sp_int_req_i) rx_state_q <= R_IDLE;
            end
            default: begin
               rx_state_q   <= R_IDLE;
               sp_int_ack_q <= 1'b0;
            end
         endcase
      end
   end

   // TX handshake: pop when the transmitter is free, pulse write_enable, wait for it to go busy
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         tx_state_q        <= T_IDLE;
         sp_write_enable_q <= 1'b0;
         sp_tx_data_q      <= '0;
      end else begin
         case (tx_state_q)
            T_IDLE: begin
               if (tx_pop) begin
                  tx_state_q        <= T_START;
                  sp_write_enable_q <= 1'b1;
                  sp_tx_data_q      <= tx_head;
               end
            end
            T_START: begin
               tx_state_q        <= T_HOLD;
               sp_write_enable_q <= 1'b0;
            end
            T_HOLD: begin
               if (!sp_write_not_busy_i) tx_state_q <= T_IDLE;
            end
            default: begin
               tx_state_q        <= T_IDLE;
               sp_write_enable_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rdata         = rdata_q;
   assign bus.ack           = ack_q;
   assign cpu_irq_o         = cpu_irq_q;
   assign sp_int_ack_o      = sp_int_ack_q;
   assign sp_tx_data_o      = sp_tx_data_q;
   assign sp_write_enable_o = sp_write_enable_q;

endmodule

// File: tb/tb_serial_mmio.sv
// Randomized self-checking bench for serial_mmio against a queue-based model of the register map.
module tb_serial_mmio;

   localparam int DEPTH = 16;
   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_STAT = 2'd1;
   localparam logic [1:0] A_CTRL = 2'd2;
   localparam logic [1:0] A_RSVD = 2'd3;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_irq, sp_int_req, sp_int_ack, sp_write_enable, sp_write_not_busy;
   logic [7:0] sp_rx_data, sp_tx_data;

   always #5 clk = ~clk;

   serial_mmio_if bus();

   serial_mmio #(.FIFO_DEPTH(16), .PTR_W(4)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .bus                 (bus),
      .cpu_irq_o           (cpu_irq),
      .sp_int_req_i        (sp_int_req),
      .sp_rx_data_i        (sp_rx_data),
      .sp_int_ack_o        (sp_int_ack),
      .sp_tx_data_o        (sp_tx_data),
      .sp_write_enable_o   (sp_write_enable),
      .sp_write_not_busy_i (sp_write_not_busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   logic       m_rx_ovr, m_tx_ovf, m_irq_en;

   // Transmitter model state
   logic [7:0] tx_got[$];
   int         viol = 0;
   int         busy_cnt = 0;
   bit         tx_block = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_status();
      return {2'b00, 1'b1, m_tx_ovf, m_rx_ovr, (tx_q.size() == 0),
              (tx_q.size() == DEPTH), (rx_q.size() != 0)};
   endfunction

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wdata = 8'h00;
      step();
      bus.ce = 1'b0;
      chk("rd_ack", bus.ack, 1);
      d = bus.rdata;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
      step();
      bus.ce = 1'b0; bus.we = 1'b0;
      chk("wr_ack", bus.ack, 1);
   endtask

   task automatic rx_send(input logic [7:0] b);
      int lat;
      int pulses;
      sp_int_req = 1'b1;
      sp_rx_data = b;
      lat = 0;
      do begin
         step();
         lat++;
      end while (sp_int_ack !== 1'b1 && lat < 8);
      chk("rx_ack_lat", lat, 1);
      if (rx_q.size() < DEPTH) rx_q.push_back(b);
      else m_rx_ovr = 1'b1;
      sp_int_req = 1'b0;
      pulses = (sp_int_ack === 1'b1) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (sp_int_ack === 1'b1) pulses++;
      end
      chk("rx_ack_pulses", pulses, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
      sp_int_req = 1'b0; sp_rx_data = 8'h00;
      step();
      step();
      chk("rst_outputs", {bus.rdata, bus.ack, cpu_irq, sp_int_ack, sp_tx_data, sp_write_enable}, 0);
      rst = 1'b0;
      rx_q.delete(); tx_q.delete();
      m_rx_ovr = 1'b0; m_tx_ovf = 1'b0; m_irq_en = 1'b0;
      step();
   endtask

   task automatic wait_tx_ready();
      for (int i = 0; i < 40 && sp_write_not_busy !== 1'b1; i++) step();
      chk("tx_ready", sp_write_not_busy, 1);
   endtask

   // Transmitter: takes a byte on write_enable, then stays busy for 10 cycles
   initial begin
      sp_write_not_busy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (sp_write_enable === 1'b1) begin
            if (sp_write_not_busy !== 1'b1) viol++;
            tx_got.push_back(sp_tx_data);
            sp_write_not_busy = 1'b0;
            busy_cnt = 10;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end else begin
            sp_write_not_busy = !tx_block;
         end
      end
   end

   initial begin
      logic [7:0] d, b, w, e;
      int op;
      int n;

      // Reset state
      do_reset();
      bus_rd(A_STAT, d); chk("rst_status", d, 8'h24);
      bus_rd(A_DATA, d); chk("rst_data_empty", d, 8'h00);
      chk("rst_irq_sp", {cpu_irq, sp_int_ack, sp_write_enable, sp_tx_data}, 0);

      // Single RX byte with interrupt
      bus_wr(A_CTRL, 8'h01); m_irq_en = 1'b1;
      bus_rd(A_CTRL, d); chk("ctrl_rd", d, 8'h01);
      rx_send(8'h5A);
      chk("irq_set", cpu_irq, 1);
      bus_rd(A_DATA, d); chk("rx_5a", d, rx_q.pop_front());
      step();
      chk("irq_clr", cpu_irq, 0);

      // RX overflow: 17 bytes into a 16-deep FIFO
      for (int i = 0; i <= 16; i++) rx_send(8'(i));
      bus_rd(A_STAT, d); chk("ovr_status", d, exp_status());
      for (int i = 0; i < 16; i++) begin
         bus_rd(A_DATA, d); chk("ovr_drain", d, 8'(i));
      end
      void'(rx_q.size());
      rx_q.delete();
      bus_wr(A_STAT, 8'h08); m_rx_ovr = 1'b0;
      bus_rd(A_STAT, d); chk("ovr_cleared", d, exp_status());

      // TX: two bytes through a slow transmitter
      wait_tx_ready();
      tx_got.delete();
      bus_wr(A_DATA, 8'h41);
      step();
      chk("tx_we_lat", sp_write_enable, 1);
      chk("tx_data_41", sp_tx_data, 8'h41);
      bus_wr(A_DATA, 8'h42);
      for (int i = 0; i < 60 && tx_got.size() < 2; i++) step();
      chk("tx_count", tx_got.size(), 2);
      e = (tx_got.size() > 0) ? tx_got.pop_front() : 8'hxx; chk("tx_byte0", e, 8'h41);
      e = (tx_got.size() > 0) ? tx_got.pop_front() : 8'hxx; chk("tx_byte1", e, 8'h42);
      chk("tx_busy_viol", viol, 0);

      // Full RX FIFO: CPU pop and RX push on the same edge
      do_reset();
      for (int i = 0; i < 16; i++) rx_send(8'h80 + 8'(i));
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = A_DATA;
      sp_int_req = 1'b1; sp_rx_data = 8'hC3;
      step();
      bus.ce = 1'b0;
      chk("simul_ack", bus.ack, 1);
      chk("simul_rdata", bus.rdata, rx_q.pop_front());
      chk("simul_int_ack", sp_int_ack, 1);
      rx_q.push_back(8'hC3);
      sp_int_req = 1'b0;
      step(); step(); step();
      bus_rd(A_STAT, d); chk("simul_status", d, exp_status());
      while (rx_q.size() > 0) begin
         bus_rd(A_DATA, d); chk("simul_drain", d, rx_q.pop_front());
      end

      // Reset during R_ACK
      sp_int_req = 1'b1; sp_rx_data = 8'h99;
      step();
      chk("rack_entered", sp_int_ack, 1);
      rst = 1'b1;
      step();
      chk("rack_rst_out", {bus.rdata, bus.ack, cpu_irq, sp_int_ack, sp_tx_data, sp_write_enable}, 0);
      rst = 1'b0; sp_int_req = 1'b0;
      step();
      bus_rd(A_STAT, d); chk("rack_rst_status", d, 8'h24);

      // Reset during T_START
      wait_tx_ready();
      bus_wr(A_DATA, 8'h77);
      step();
      chk("tstart_entered", sp_write_enable, 1);
      rst = 1'b1;
      step();
      chk("tstart_rst_out", {bus.rdata, bus.ack, cpu_irq, sp_int_ack, sp_tx_data, sp_write_enable}, 0);
      rst = 1'b0;
      step();
      bus_rd(A_STAT, d); chk("tstart_rst_status", d, 8'h24);

      // Randomized register traffic with the transmitter held busy
      do_reset();
      tx_block = 1'b1;
      for (int i = 0; i < 40 && sp_write_not_busy !== 1'b0; i++) step();
      chk("tx_blocked", sp_write_not_busy, 0);
      tx_got.delete();
      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 8);
         b  = 8'($urandom);
         case (op)
            0, 7: rx_send(b);
            1: begin
               e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
               bus_rd(A_DATA, d); chk("rand_data", d, e);
            end
            2: begin
               bus_rd(A_STAT, d); chk("rand_status", d, exp_status());
            end
            3, 8: begin
               bus_wr(A_DATA, b);
               if (tx_q.size() < DEPTH) tx_q.push_back(b);
               else m_tx_ovf = 1'b1;
            end
            4: begin
               w = b & 8'h3F;
               bus_wr(A_STAT, w);
               if (w[3]) m_rx_ovr = 1'b0;
               if (w[4]) m_tx_ovf = 1'b0;
            end
            5: begin
               bus_wr(A_CTRL, b); m_irq_en = b[0];
            end
            default: begin
               if (b[0]) begin
                  bus_rd(A_CTRL, d); chk("rand_ctrl", d, {7'b0, m_irq_en});
               end else begin
                  bus_wr(A_RSVD, b);
                  bus_rd(A_RSVD, d); chk("rand_rsvd", d, 8'h00);
               end
            end
         endcase
         step();
         chk("rand_ack_once", bus.ack, 0);
         chk("rand_irq", cpu_irq, m_irq_en && (rx_q.size() != 0));
      end

      // Release the transmitter and compare everything it receives
      tx_block = 1'b0;
      n = tx_q.size();
      for (int i = 0; i < DEPTH * 14 + 60 && tx_got.size() < n; i++) step();
      chk("rand_tx_count", tx_got.size(), n);
      while (tx_q.size() > 0 && tx_got.size() > 0) begin
         chk("rand_tx_byte", tx_got.pop_front(), tx_q.pop_front());
      end
      chk("rand_tx_viol", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
